// File: rtl/mor1kx_trace_capture.sv
// Traceport capture buffer: decodes l.nop start/stop/exit markers and queues retired-instruction
// records from open windows for valid/ready readout. Optional PC filter: MOR1KX_TRACE_CAPTURE_FILTER_EN.
module mor1kx_trace_capture #(
   parameter int          OPTION_OPERAND_WIDTH = 32,
   parameter int          OPTION_RF_ADDR_WIDTH = 5,
   parameter int          DEPTH                = 16,
   parameter int          WRAP_MODE            = 0,
   parameter int          AUTOSTART            = 0,
   parameter logic [31:0] START_NOP            = 32'h15000064,
   parameter logic [31:0] STOP_NOP             = 32'h150000c8,
   localparam int         AW                   = $clog2(DEPTH)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            traceport_exec_valid,
   input  logic [31:0]                     traceport_exec_pc,
   input  logic [31:0]                     traceport_exec_insn,
   input  logic [OPTION_OPERAND_WIDTH-1:0] traceport_exec_wbdata,
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] traceport_exec_wbreg,
   input  logic                            traceport_exec_wben,
`ifdef MOR1KX_TRACE_CAPTURE_FILTER_EN
   input  logic [31:0]                     filter_lo,
   input  logic [31:0]                     filter_hi,
`endif
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [31:0]                     out_pc,
   output logic [31:0]                     out_insn,
   output logic [OPTION_OPERAND_WIDTH-1:0] out_wbdata,
   output logic [OPTION_RF_ADDR_WIDTH-1:0] out_wbreg,
   output logic                            out_wben,
   output logic [31:0]                     out_seq,
   output logic [AW:0]                     level,
   output logic [31:0]                     insn_count,
   output logic [15:0]                     drop_count,
   output logic                            overflow,
   output logic                            capturing,
   output logic                            finish
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CAPTURE = 2'd1;
   localparam logic [1:0] STOPPED = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [31:0] EXIT_NOP_A = 32'h15000001;
   localparam logic [31:0] EXIT_NOP_B = 32'h1500000c;
   localparam logic [AW:0] DEPTH_L    = DEPTH[AW:0];
   localparam bit          WRAP       = (WRAP_MODE != 0);

   logic [1:0]    state, state_nxt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level_nxt;

   logic [31:0]                     mem_pc     [DEPTH];
   logic [31:0]                     mem_insn   [DEPTH];
   logic [OPTION_OPERAND_WIDTH-1:0] mem_wbdata [DEPTH];
   logic [OPTION_RF_ADDR_WIDTH-1:0] mem_wbreg  [DEPTH];
   logic                            mem_wben   [DEPTH];
   logic [31:0]                     mem_seq    [DEPTH];

   logic is_start, is_stop, is_exit, is_marker, in_range;
   logic push_req, pop, full, accept, drop, wr_en, rd_adv;

   assign is_start  = (traceport_exec_insn == START_NOP);
   assign is_stop   = (traceport_exec_insn == STOP_NOP);
   assign is_exit   = (traceport_exec_insn == EXIT_NOP_A) || (traceport_exec_insn == EXIT_NOP_B);
   assign is_marker = is_start || is_stop || is_exit;

`ifdef MOR1KX_TRACE_CAPTURE_FILTER_EN
   assign in_range = (traceport_exec_pc >= filter_lo) && (traceport_exec_pc <= filter_hi);
`else
   assign in_range = 1'b1;
`endif

   assign out_valid = (level != '0);
   assign full      = (level == DEPTH_L);
   assign pop       = out_valid && out_ready;
   assign push_req  = traceport_exec_valid && (state == CAPTURE) && !is_marker && in_range;
   // A pop in the same cycle frees the slot, so a push into a full buffer still fits.
   assign accept    = push_req && (!full || pop);
   assign drop      = push_req && full && !pop;
   assign wr_en     = accept || (drop && WRAP);
   assign rd_adv    = pop || (drop && WRAP);

   always_comb begin
      state_nxt = state;
      if (traceport_exec_valid) begin
         if (is_exit)
            state_nxt = DONE;
         else if (is_start && (state == IDLE || state == STOPPED))
            state_nxt = CAPTURE;
         else if (is_stop && state == CAPTURE)
            state_nxt = STOPPED;
      end
   end

   always_comb begin
      level_nxt = level;
      if (accept && !pop)
         level_nxt = level + 1'b1;
      else if (!push_req && pop)
         level_nxt = level - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= (AUTOSTART != 0) ? CAPTURE : IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         insn_count <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         if (traceport_exec_valid)
            insn_count <= insn_count + 1'b1;
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_adv)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF)
               drop_count <= drop_count + 1'b1;
         end
      end
   end

   // Record storage carries no reset; validity is tracked solely by the pointers and level.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem_pc[wr_ptr]     <= traceport_exec_pc;
         mem_insn[wr_ptr]   <= traceport_exec_insn;
         mem_wbdata[wr_ptr] <= traceport_exec_wbdata;
         mem_wbreg[wr_ptr]  <= traceport_exec_wbreg;
         mem_wben[wr_ptr]   <= traceport_exec_wben;
         mem_seq[wr_ptr]    <= insn_count;
      end
   end

   assign out_pc     = mem_pc[rd_ptr];
   assign out_insn   = mem_insn[rd_ptr];
   assign out_wbdata = mem_wbdata[rd_ptr];
   assign out_wbreg  = mem_wbreg[rd_ptr];
   assign out_wben   = mem_wben[rd_ptr];
   assign out_seq    = mem_seq[rd_ptr];
   assign capturing  = (state == CAPTURE);
   assign finish     = (state == DONE);

endmodule

// File: tb/tb_mor1kx_trace_capture.sv
// Bench for mor1kx_trace_capture: a stop-on-full and a ring instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_mor1kx_trace_capture;

   localparam int DEPTH = 16;
   localparam logic [31:0] START = 32'h15000064;
   localparam logic [31:0] STOP  = 32'h150000c8;
   localparam logic [31:0] EXIT1 = 32'h15000001;
   localparam logic [31:0] EXIT2 = 32'h1500000c;
   localparam logic [31:0] PLAIN = 32'he0211800;
   localparam int M_IDLE = 0, M_CAP = 1, M_STOPPED = 2, M_DONE = 3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
      logic [31:0] wbdata;
      logic [4:0]  wbreg;
      logic        wben;
      logic [31:0] seq;
   } rec_t;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, in_wben = 1'b0, in_ready = 1'b0;
   logic [31:0] in_pc = '0, in_insn = '0, in_wbdata = '0;
   logic [4:0]  in_wbreg = '0;
   logic [31:0] flt_lo = 32'h40, flt_hi = 32'h300;

   logic        v0, v1, we0, we1, ovf0, ovf1, cap0, cap1, fin0, fin1;
   logic [31:0] pc0, pc1, ins0, ins1, wd0, wd1, seq0, seq1, cnt0, cnt1;
   logic [4:0]  wr0, wr1, lvl0, lvl1;
   logic [15:0] dc0, dc1;

   mor1kx_trace_capture #(.DEPTH(DEPTH), .WRAP_MODE(0)) dut0 (
      .clk(clk), .rst(rst),
      .traceport_exec_valid(in_valid), .traceport_exec_pc(in_pc), .traceport_exec_insn(in_insn),
      .traceport_exec_wbdata(in_wbdata), .traceport_exec_wbreg(in_wbreg), .traceport_exec_wben(in_wben),
`ifdef MOR1KX_TRACE_CAPTURE_FILTER_EN
      .filter_lo(flt_lo), .filter_hi(flt_hi),
`endif
      .out_valid(v0), .out_ready(in_ready), .out_pc(pc0), .out_insn(ins0), .out_wbdata(wd0),
      .out_wbreg(wr0), .out_wben(we0), .out_seq(seq0), .level(lvl0), .insn_count(cnt0),
      .drop_count(dc0), .overflow(ovf0), .capturing(cap0), .finish(fin0));

   mor1kx_trace_capture #(.DEPTH(DEPTH), .WRAP_MODE(1)) dut1 (
      .clk(clk), .rst(rst),
      .traceport_exec_valid(in_valid), .traceport_exec_pc(in_pc), .traceport_exec_insn(in_insn),
      .traceport_exec_wbdata(in_wbdata), .traceport_exec_wbreg(in_wbreg), .traceport_exec_wben(in_wben),
`ifdef MOR1KX_TRACE_CAPTURE_FILTER_EN
      .filter_lo(flt_lo), .filter_hi(flt_hi),
`endif
      .out_valid(v1), .out_ready(in_ready), .out_pc(pc1), .out_insn(ins1), .out_wbdata(wd1),
      .out_wbreg(wr1), .out_wben(we1), .out_seq(seq1), .level(lvl1), .insn_count(cnt1),
      .drop_count(dc1), .overflow(ovf1), .capturing(cap1), .finish(fin1));

   // reference model
   rec_t        q0[$], q1[$];
   int          mst;
   logic [31:0] m_count;
   logic [15:0] m_drop[2];
   bit          m_ovf[2];
   int          n_checks = 0, n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_filter(input logic [31:0] pc);
`ifdef MOR1KX_TRACE_CAPTURE_FILTER_EN
      return (pc >= flt_lo) && (pc <= flt_hi);
`else
      return (pc == pc);
`endif
   endfunction

   function automatic int q_size(input int m);
      return (m == 0) ? q0.size() : q1.size();
   endfunction

   task automatic q_pop(input int m);
      if (m == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
   endtask

   task automatic q_push(input int m, input rec_t r);
      if (m == 0) q0.push_back(r);
      else        q1.push_back(r);
   endtask

   task automatic model_fifo(input int m, input bit push, input bit rdy, input rec_t r);
      bit was_full, pop;
      was_full = (q_size(m) == DEPTH);
      pop = (q_size(m) > 0) && rdy;
      if (pop) q_pop(m);
      if (push) begin
         if (!was_full || pop) q_push(m, r);
         else begin
            if (m_drop[m] != 16'hFFFF) m_drop[m]++;
            m_ovf[m] = 1'b1;
            if (m == 1) begin
               q_pop(1);
               q_push(1, r);
            end
         end
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      mst = M_IDLE;
      m_count = '0;
      m_drop[0] = '0; m_drop[1] = '0;
      m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
   endtask

   task automatic model_edge();
      bit st, sp, ex, push;
      rec_t r;
      st = (in_insn == START);
      sp = (in_insn == STOP);
      ex = (in_insn == EXIT1) || (in_insn == EXIT2);
      push = in_valid && (mst == M_CAP) && !(st || sp || ex) && in_filter(in_pc);
      r.pc = in_pc; r.insn = in_insn; r.wbdata = in_wbdata;
      r.wbreg = in_wbreg; r.wben = in_wben; r.seq = m_count;
      model_fifo(0, push, in_ready, r);
      model_fifo(1, push, in_ready, r);
      if (in_valid) begin
         if (ex) mst = M_DONE;
         else if (st && (mst == M_IDLE || mst == M_STOPPED)) mst = M_CAP;
         else if (sp && mst == M_CAP) mst = M_STOPPED;
         m_count++;
      end
   endtask

   task automatic check_one(input int m, input logic v, input logic [4:0] lvl, input rec_t head,
                            input logic [15:0] dc, input logic ovf, input logic [31:0] cnt,
                            input logic cap, input logic fin);
      string p;
      rec_t e;
      p = $sformatf("d%0d.", m);
      check({p, "out_valid"}, v, q_size(m) > 0);
      check({p, "level"}, lvl, q_size(m));
      check({p, "drop_count"}, dc, m_drop[m]);
      check({p, "overflow"}, ovf, m_ovf[m]);
      check({p, "insn_count"}, cnt, m_count);
      check({p, "capturing"}, cap, mst == M_CAP);
      check({p, "finish"}, fin, mst == M_DONE);
      if (q_size(m) > 0) begin
         e = (m == 0) ? q0[0] : q1[0];
         check({p, "out_pc"}, head.pc, e.pc);
         check({p, "out_insn"}, head.insn, e.insn);
         check({p, "out_wbdata"}, head.wbdata, e.wbdata);
         check({p, "out_wbreg"}, head.wbreg, e.wbreg);
         check({p, "out_wben"}, head.wben, e.wben);
         check({p, "out_seq"}, head.seq, e.seq);
      end
   endtask

   task automatic check_all();
      check_one(0, v0, lvl0, {pc0, ins0, wd0, wr0, we0, seq0}, dc0, ovf0, cnt0, cap0, fin0);
      check_one(1, v1, lvl1, {pc1, ins1, wd1, wr1, we1, seq1}, dc1, ovf1, cnt1, cap1, fin1);
   endtask

   // driver tasks: inputs change on the falling edge, outputs are sampled on the next falling edge
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn, input logic rdy);
      in_valid = v; in_pc = pc; in_insn = insn; in_ready = rdy;
      in_wbdata = $urandom; in_wbreg = 5'($urandom_range(0, 31)); in_wben = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'($urandom_range(0, 1)); in_insn = PLAIN; in_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      check_all();
   endtask

   initial begin
      int r;
      logic [31:0] insn;
      model_reset();
      do_reset();

      // idle instructions are counted, not captured
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h80 + 32'(4 * i), PLAIN, 1'b0);
      check("idle.level", lvl0, 5'd0);
      check("idle.count", cnt0, 32'd3);

      // one start/stop window of four records
      do_reset();
      drive(1'b1, 32'h0f0, START, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, 32'h100 + 32'(4 * i), PLAIN, 1'b0);
      drive(1'b1, 32'h110, STOP, 1'b0);
      check("win.level", lvl0, 5'd4);
      check("win.head_pc", pc0, 32'h100);
      check("win.out_seq", seq0, 32'd1);
      check("win.count", cnt0, 32'd6);
      check("win.capturing", cap0, 1'b0);

      // 20 records into 16 entries: drop vs overwrite
      do_reset();
      drive(1'b1, 32'h1f0, START, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 32'h200 + 32'(4 * i), PLAIN, 1'b0);
      check("full.d0_head", pc0, 32'h200);
      check("full.d1_head", pc1, 32'h210);
      check("full.d0_drops", dc0, 16'd4);
      check("full.d1_drops", dc1, 16'd4);
      drive(1'b1, 32'h250, PLAIN, 1'b1);
      check("full_pop.level", lvl0, 5'd16);
      check("full_pop.drops", dc0, 16'd4);
      drive(1'b1, 32'h254, EXIT2, 1'b0);
      drive(1'b1, 32'h258, START, 1'b0);
      check("done.finish", fin0, 1'b1);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 32'h0, PLAIN, 1'b1);
      check("drain.d0_valid", v0, 1'b0);
      check("drain.d1_valid", v1, 1'b0);

      // reset in the middle of a window
      drive(1'b0, 32'h0, PLAIN, 1'b0);
      do_reset();
      drive(1'b1, 32'h1f0, START, 1'b0);
      for (int i = 0; i < 7; i++) drive(1'b1, 32'h120 + 32'(4 * i), PLAIN, 1'b0);
      check("mid.level_before", lvl0, 5'd7);
      do_reset();
      check("mid.level", lvl0, 5'd0);
      check("mid.valid", v0, 1'b0);
      drive(1'b1, 32'h130, PLAIN, 1'b0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         else begin
            r = int'($urandom_range(0, 99));
            if (r < 6)       insn = START;
            else if (r < 11) insn = STOP;
            else if (r < 12) insn = ($urandom_range(0, 1) != 0) ? EXIT1 : EXIT2;
            else             insn = $urandom;
            drive(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)) << 2, insn,
                  1'($urandom_range(0, 2) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mor1kx_trace_capture.md
Name: mor1kx_trace_capture

Overview:
- Synthesizable, parametrised successor to the simulation-only traceport monitor.
- Watches the mor1kx execute traceport and decodes the marker l.nop instructions:
  - 0x64: start.
  - 0xc8: stop.
  - 0x01 / 0x0c: exit.
- Stores retired-instruction records from the open trace windows in an on-chip buffer; buffer drains through a valid/ready port.
- Sits beside the CPU, fed by the traceport; read by a debug/bus unit.

Parameters:
- OPTION_OPERAND_WIDTH, 32, width of wbdata.
- OPTION_RF_ADDR_WIDTH, 5, width of wbreg.
- DEPTH, 16, buffer entries; power of 2, >=2. AW = $clog2(DEPTH).
- WRAP_MODE, 0, 0 = stop-on-full (drop new records); 1 = ring (overwrite oldest).
- AUTOSTART, 0, 1 = leave reset already in CAPTURE.
- START_NOP, 32'h15000064, start-window marker.
- STOP_NOP, 32'h150000c8, stop-window marker.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- traceport_exec_valid  in  1  instruction retired this cycle.
- traceport_exec_pc  in  32  retired PC.
- traceport_exec_insn  in  32  retired instruction word.
- traceport_exec_wbdata  in  OPTION_OPERAND_WIDTH  writeback data.
- traceport_exec_wbreg  in  OPTION_RF_ADDR_WIDTH  writeback register.
- traceport_exec_wben  in  1  writeback enable.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts head entry.
- out_pc, out_insn, out_wbdata, out_wbreg, out_wben  out  as inputs  head record.
- out_seq  out  32  value of insn_count when the head record was captured.
- level  out  AW+1  entries held.
- insn_count  out  32  retired instructions since reset; wraps.
- drop_count  out  16  records lost; saturates at 16'hFFFF.
- overflow  out  1  sticky: set on first lost record.
- capturing  out  1  state == CAPTURE.
- finish  out  1  state == DONE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - Pointers, level, insn_count, drop_count, overflow, finish all 0.
  - State = CAPTURE if AUTOSTART, else IDLE.
  - Reset mid-operation discards buffer contents immediately; out_valid is 0 the next cycle.
- States: IDLE, CAPTURE, STOPPED, DONE. All decoding applies only when traceport_exec_valid=1.
- Transitions:
  - IDLE or STOPPED + START_NOP -> CAPTURE.
  - CAPTURE + STOP_NOP -> STOPPED.
  - Any state + insn 32'h15000001 or 32'h1500000c -> DONE.
  - DONE is terminal until reset. Readout continues in DONE.
- Capture:
  - In CAPTURE, every valid instruction that is not a marker (START, STOP, exit) is pushed.
  - Marker instructions are never recorded.
  - START_NOP while already in CAPTURE is ignored and not recorded.
- insn_count increments on every valid cycle in every state, markers included.
- out_seq holds the pre-increment count for the record's own cycle.
- Latency: record pushed at edge N appears on out_* (if buffer was empty) after edge N, i.e. out_valid high in cycle N+1.
- Pop: occurs when out_valid && out_ready; head advances at the edge. out_* is combinational from the head pointer.
- Push with buffer not full: accepted; level+1 unless a pop occurs in the same cycle.
- Push with full buffer and simultaneous pop: push accepted, level unchanged, nothing lost.
- Push with full buffer and no pop:
  - WRAP_MODE=0: record dropped.
  - WRAP_MODE=1: oldest record overwritten; read pointer advances; level stays DEPTH.
  - Both modes: drop_count+1 (saturating), overflow=1.
- Pointers are AW bits and wrap naturally modulo DEPTH. level is AW+1 bits and never exceeds DEPTH.
- Pop when empty: ignored.

Optional Feature:
- Macro: MOR1KX_TRACE_CAPTURE_FILTER_EN.
- When defined, adds two ports: filter_lo in 32 and filter_hi in 32.
- A non-marker instruction is pushed only if filter_lo <= pc <= filter_hi (unsigned, inclusive).
- Filtered-out instructions are not counted as drops. insn_count and marker decoding are unaffected.
- When not defined, there are no filter ports and every non-marker instruction in CAPTURE is pushed.

Test Plan:
- Reset, then retire 3 non-marker instructions in IDLE -> level=0, insn_count=3, capturing=0.
- START_NOP, then 4 instructions pc 0x100..0x10C, then STOP_NOP, out_ready=0 -> level=4, head pc 0x100, out_seq=1, capturing=0, insn_count=6.
- DEPTH=16, WRAP_MODE=0, 20 instructions in CAPTURE with no reads -> level=16, drop_count=4, overflow=1, head = first record.
- WRAP_MODE=1, same stimulus -> level=16, drop_count=4, head = 5th record, tail = 20th record.
- Full buffer, out_ready=1 during a push -> level stays 16, drop_count unchanged. Then 32'h1500000c -> finish=1, further START_NOP ignored, 16 pops drain, out_valid=0.
- rst low for one cycle mid-capture with level=7 -> next cycle level=0, out_valid=0, state IDLE.
